// File: rtl/spi_pkg.sv
// Shared SPI responder items: mode constants, CPOL/CPHA extraction, FSM state type.
package spi_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'd0;
  localparam logic [1:0] SPI_MODE1 = 2'd1;
  localparam logic [1:0] SPI_MODE2 = 2'd2;
  localparam logic [1:0] SPI_MODE3 = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } resp_state_e;

  function automatic logic spi_cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  function automatic logic spi_cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// N-stage synchronizer for one asynchronous SPI pin, with rise/fall detection
// on the synchronized level. RST_VAL is the pin's idle level.
module spi_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;

  // Synchronizer chain plus one delayed copy of its output for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {STAGES{RST_VAL}};
      prev_r <= RST_VAL;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
      prev_r <= sync_r[STAGES-1];
    end
  end

  assign q    = sync_r[STAGES-1];
  assign rise = sync_r[STAGES-1] & ~prev_r;
  assign fall = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI target: oversamples SPI pins on i_Clk, shifts MOSI in and MISO out per SPI_MODE.
// Optional frame byte counter enabled by defining SPI_SLAVE_BYTE_COUNT_EN.
module spi_slave_responder
  import spi_pkg::*;
#(
  parameter logic [1:0] SPI_MODE    = SPI_MODE0,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEFAULT_TX  = 8'hFF
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_TX_Underrun,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_Busy,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_CS_n,
  input  logic       i_SPI_MOSI,
  output logic       o_SPI_MISO,
  output logic       o_SPI_MISO_OE
`ifdef SPI_SLAVE_BYTE_COUNT_EN
  ,
  output logic [7:0] o_Frame_Count
`endif
);

  localparam logic CPOL = spi_cpol(SPI_MODE);
  localparam logic CPHA = spi_cpha(SPI_MODE);

  logic sclk_q_s, sclk_rise_s, sclk_fall_s;
  logic cs_q_s, cs_rise_s, cs_fall_s;
  logic mosi_q_s, mosi_rise_s, mosi_fall_s;
  logic lead_s, trail_s, sample_s, shift_s;
  logic load_s, leave_s, active_s, byte_done_s;
  logic [7:0] load_byte_s;
  logic unused_s;

  resp_state_e state_r, state_nxt;
  logic [7:0] hold_r;
  logic       tx_ready_r;
  logic [7:0] tx_shift_r;
  logic       miso_r;
  logic       underrun_r;
  logic [7:0] rx_shift_r;
  logic [2:0] bit_cnt_r;
  logic [7:0] rx_byte_r;
  logic       rx_dv_r;
  logic       busy_r;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
    .clk(i_Clk), .rst_n(i_Rst_L), .d(i_SPI_Clk),
    .q(sclk_q_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(i_Clk), .rst_n(i_Rst_L), .d(i_SPI_CS_n),
    .q(cs_q_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(i_Clk), .rst_n(i_Rst_L), .d(i_SPI_MOSI),
    .q(mosi_q_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
  );

  // Leading edge leaves the CPOL idle level; CPHA picks which edge samples
  assign lead_s      = CPOL ? sclk_fall_s : sclk_rise_s;
  assign trail_s     = CPOL ? sclk_rise_s : sclk_fall_s;
  assign sample_s    = CPHA ? trail_s : lead_s;
  assign shift_s     = CPHA ? lead_s : trail_s;
  assign load_byte_s = tx_ready_r ? DEFAULT_TX : hold_r;

  // FSM state register
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next state, byte-load decision and frame qualifiers
  always_comb begin
    state_nxt = state_r;
    load_s    = 1'b0;
    leave_s   = 1'b0;
    active_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_nxt = ST_ACTIVE;
          load_s    = !CPHA;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (cs_q_s) begin
          state_nxt = ST_IDLE;
          leave_s   = 1'b1;
        end else begin
          state_nxt = ST_ACTIVE;
          active_s  = 1'b1;
          load_s    = shift_s && (bit_cnt_r == 3'd0);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign byte_done_s = active_s && sample_s && (bit_cnt_r == 3'd7);

  // Holding register: a write is taken only while empty, a load empties it
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hold_r     <= 8'h00;
      tx_ready_r <= 1'b1;
    end else if (i_TX_DV && tx_ready_r) begin
      hold_r     <= i_TX_Byte;
      tx_ready_r <= 1'b0;
    end else if (load_s && !tx_ready_r) begin
      tx_ready_r <= 1'b1;
    end
  end

  // TX shift register and MISO; a load presents bit 7 immediately
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      tx_shift_r <= 8'h00;
      miso_r     <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= load_s && tx_ready_r;
      if (leave_s) begin
        tx_shift_r <= 8'h00;
        miso_r     <= 1'b0;
      end else if (load_s) begin
        tx_shift_r <= {load_byte_s[6:0], 1'b0};
        miso_r     <= load_byte_s[7];
      end else if (active_s && shift_s) begin
        tx_shift_r <= {tx_shift_r[6:0], 1'b0};
        miso_r     <= tx_shift_r[7];
      end
    end
  end

  // RX shift register, bit counter and byte-complete pulse
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rx_shift_r <= 8'h00;
      bit_cnt_r  <= 3'd0;
      rx_byte_r  <= 8'h00;
      rx_dv_r    <= 1'b0;
    end else begin
      rx_dv_r <= 1'b0;
      if (leave_s) begin
        rx_shift_r <= 8'h00;
        bit_cnt_r  <= 3'd0;
      end else if (active_s && sample_s) begin
        rx_shift_r <= {rx_shift_r[6:0], mosi_q_s};
        bit_cnt_r  <= bit_cnt_r + 3'd1;
        if (bit_cnt_r == 3'd7) begin
          rx_byte_r <= {rx_shift_r[6:0], mosi_q_s};
          rx_dv_r   <= 1'b1;
        end
      end
    end
  end

  // Busy tracks the synchronized chip select through the FSM
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt == ST_ACTIVE);
    end
  end

`ifdef SPI_SLAVE_BYTE_COUNT_EN
  logic [7:0] frame_cnt_r;

  // Complete bytes in the current frame; restarts at every CS fall
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      frame_cnt_r <= 8'd0;
    end else if ((state_r == ST_IDLE) && cs_fall_s) begin
      frame_cnt_r <= 8'd0;
    end else if (byte_done_s) begin
      frame_cnt_r <= frame_cnt_r + 8'd1;
    end
  end

  assign o_Frame_Count = frame_cnt_r;
  assign unused_s      = ^{sclk_q_s, cs_rise_s, mosi_rise_s, mosi_fall_s};
`else
  assign unused_s      = ^{sclk_q_s, cs_rise_s, mosi_rise_s, mosi_fall_s, byte_done_s};
`endif

  assign o_TX_Ready    = tx_ready_r;
  assign o_TX_Underrun = underrun_r;
  assign o_RX_DV       = rx_dv_r;
  assign o_RX_Byte     = rx_byte_r;
  assign o_Busy        = busy_r;
  assign o_SPI_MISO    = miso_r;
  assign o_SPI_MISO_OE = busy_r;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Scoreboard bench: one responder per SPI mode, driven by a behavioural SPI master.
module tb_spi_slave_responder;

  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic [3:0] tx_dv = 4'b0000;
  logic [3:0] tx_ready, underrun, rx_dv, busy, miso, oe;
  logic [3:0] sclk = 4'b1100;
  logic [3:0] cs_n = 4'b1111;
  logic       mosi = 1'b0;
  logic [7:0] rx_byte [4];
`ifdef SPI_SLAVE_BYTE_COUNT_EN
  logic [7:0] fcount [4];
`endif

  logic [7:0] rx_exp_q[$];
  logic [7:0] feed_q[$];
  logic [7:0] raw_q[$];
  int errors = 0;
  int checks = 0;
  int under_cnt = 0;
  int cur = 0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    spi_slave_responder #(.SPI_MODE(2'(m)), .SYNC_STAGES(2), .DEFAULT_TX(8'hFF)) u_dut (
      .i_Clk(clk), .i_Rst_L(rst_n),
      .i_TX_Byte(tx_byte), .i_TX_DV(tx_dv[m]), .o_TX_Ready(tx_ready[m]),
      .o_TX_Underrun(underrun[m]), .o_RX_DV(rx_dv[m]), .o_RX_Byte(rx_byte[m]),
      .o_Busy(busy[m]), .i_SPI_Clk(sclk[m]), .i_SPI_CS_n(cs_n[m]),
      .i_SPI_MOSI(mosi), .o_SPI_MISO(miso[m]), .o_SPI_MISO_OE(oe[m])
`ifdef SPI_SLAVE_BYTE_COUNT_EN
      , .o_Frame_Count(fcount[m])
`endif
    );
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Monitor: every RX_DV pops the next expected byte; underrun pulses are counted
  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (rx_dv[m]) begin
        if (rx_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: mode %0d got %0h expected none", m, rx_byte[m]);
        end else begin
          chk("rx_byte", {24'd0, rx_byte[m]}, {24'd0, rx_exp_q.pop_front()});
          chk("rx_mode", m, cur);
        end
      end
      if (underrun[m]) under_cnt++;
    end
  end

  // Feeder: writes queued bytes when ready; raw bytes are strobed regardless of ready
  always @(negedge clk) begin
    tx_dv = 4'b0000;
    if (raw_q.size() != 0) begin
      tx_byte    = raw_q.pop_front();
      tx_dv[cur] = 1'b1;
    end else if (feed_q.size() != 0 && tx_ready[cur]) begin
      tx_byte    = feed_q.pop_front();
      tx_dv[cur] = 1'b1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    cs_n[cur] = 1'b0;
    cyc(10);
  endtask

  task automatic cs_high();
    cyc(H);
    cs_n[cur] = 1'b1;
    cyc(12);
  endtask

  task automatic xfer(input logic [7:0] b, input int nbits, input bit chk_miso,
                      input logic [7:0] exp_miso);
    logic cpol, cpha;
    logic [7:0] r;
    cpol = cur[1];
    cpha = cur[0];
    r = 8'h00;
    if (nbits == 8) rx_exp_q.push_back(b);
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi = b[i];
        cyc(H);
        r[i] = miso[cur];
        sclk[cur] = ~cpol;
        cyc(H);
        sclk[cur] = cpol;
      end else begin
        cyc(H);
        sclk[cur] = ~cpol;
        mosi = b[i];
        cyc(H);
        r[i] = miso[cur];
        sclk[cur] = cpol;
      end
    end
    if (chk_miso) chk("miso_byte", {24'd0, r}, {24'd0, exp_miso});
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tx3 [3];
    cyc(3);
    chk("rst_tx_ready", tx_ready, 4'hF);
    chk("rst_busy", busy, 4'h0);
    chk("rst_oe", oe, 4'h0);
    chk("rst_miso", miso, 4'h0);
    chk("rst_rx_dv", rx_dv, 4'h0);
    chk("rst_underrun", underrun, 4'h0);
    chk("rst_rx_byte", {rx_byte[0], rx_byte[1], rx_byte[2], rx_byte[3]}, 32'h0);
    rst_n = 1'b1;
    cyc(4);

    // Mode 0 single byte
    cur = 0;
    feed_q.push_back(8'h3C);
    cyc(4);
    chk("tx_ready_after_write", tx_ready[0], 1'b0);
    cs_low();
    chk("busy_active", {busy[0], oe[0]}, 2'b11);
    xfer(8'hA5, 8, 1'b1, 8'h3C);
    cs_high();
    chk("busy_idle", {busy[0], oe[0]}, 2'b00);

    // Modes 1..3, three-byte frames
    tx3[0] = 8'h10; tx3[1] = 8'h20; tx3[2] = 8'h30;
    for (int m = 1; m < 4; m++) begin
      cur = m;
      for (int k = 0; k < 3; k++) feed_q.push_back(tx3[k]);
      cyc(4);
      under_cnt = 0;
      cs_low();
      for (int k = 0; k < 3; k++) xfer(8'(k + 1), 8, 1'b1, tx3[k]);
      cs_high();
      if (m[0]) chk("underrun_fed_frame", under_cnt, 0);
`ifdef SPI_SLAVE_BYTE_COUNT_EN
      chk("frame_count_3", {24'd0, fcount[m]}, 32'd3);
`endif
    end

    // Mode 1 underrun: nothing queued
    cur = 1;
    under_cnt = 0;
    cs_low();
`ifdef SPI_SLAVE_BYTE_COUNT_EN
    chk("frame_count_clear", {24'd0, fcount[1]}, 32'd0);
`endif
    xfer(8'h77, 8, 1'b1, 8'hFF);
    cs_high();
    chk("underrun_pulses", under_cnt, 1);

    // Mode 0: CS rise after 5 bits, holding byte survives into the next frame
    cur = 0;
    cs_low();
    feed_q.push_back(8'h6B);
    xfer(8'h9E, 5, 1'b0, 8'h00);
    cs_high();
    chk("hold_kept_ready", tx_ready[0], 1'b0);
    cs_low();
    xfer(8'hC3, 8, 1'b1, 8'h6B);
    cs_high();

    // Mode 0: second write while not ready is ignored
    raw_q.push_back(8'h11);
    raw_q.push_back(8'h22);
    cyc(4);
    cs_low();
    xfer(8'h5C, 8, 1'b1, 8'h11);
    cs_high();

    // Mode 0: asynchronous reset mid-byte
    feed_q.push_back(8'h5A);
    cyc(4);
    cs_low();
    xfer(8'hF0, 3, 1'b0, 8'h00);
    rst_n = 1'b0;
    #1;
    chk("arst_tx_ready", tx_ready[0], 1'b1);
    chk("arst_busy_oe", {busy[0], oe[0]}, 2'b00);
    chk("arst_miso", miso[0], 1'b0);
    chk("arst_pulses", {rx_dv[0], underrun[0]}, 2'b00);
    chk("arst_rx_byte", {24'd0, rx_byte[0]}, 32'd0);
    cs_n = 4'b1111;
    sclk = 4'b1100;
    cyc(3);
    rst_n = 1'b1;
    cyc(4);

    // Mode 0: clean transfer after reset
    feed_q.push_back(8'hE7);
    cyc(4);
    cs_low();
    xfer(8'h18, 8, 1'b1, 8'hE7);
    cs_high();

    cyc(20);
    chk("rx_queue_drained", rx_exp_q.size(), 0);
    chk("feed_queue_drained", feed_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
